// File: rtl/mux8_3to1_pkg.sv
// Shared constants for the registered 3-input selector.
// Select codes and the default data width live here.
package mux8_3to1_pkg;

    localparam int DEF_WIDTH = 8;

    localparam logic [1:0] SEL_I1   = 2'd0;
    localparam logic [1:0] SEL_I2   = 2'd1;
    localparam logic [1:0] SEL_I3   = 2'd2;
    localparam logic [1:0] SEL_NONE = 2'd3;

endpackage

// File: rtl/mux8_3to1_if.sv
// Bundle of data/select inputs and registered outputs of the selector.
// The master drives data and select; the slave returns q and err.
interface mux8_3to1_if
    import mux8_3to1_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);

    logic [WIDTH-1:0] i1;
    logic [WIDTH-1:0] i2;
    logic [WIDTH-1:0] i3;
    logic [1:0]       s;
    logic [WIDTH-1:0] q;
    logic             err;

    modport master (
        output i1, i2, i3, s,
        input  q, err
    );

    modport slave (
        input  i1, i2, i3, s,
        output q, err
    );

endinterface

// File: rtl/mux8_3to1.sv
// Registered 3-to-1 selector; code 3 selects zero and raises ERR.
// One output register stage, synchronous active-high reset.
module mux8_3to1
    import mux8_3to1_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] I1,
    input  logic [WIDTH-1:0] I2,
    input  logic [WIDTH-1:0] I3,
    input  logic [1:0]       S,
    output logic [WIDTH-1:0] Q,
    output logic             ERR
);

    logic [WIDTH-1:0] sel_d;
    logic             err_d;

    always_comb begin
        sel_d = '0;
        err_d = 1'b0;
        case (S)
            SEL_I1:   sel_d = I1;
            SEL_I2:   sel_d = I2;
            SEL_I3:   sel_d = I3;
            SEL_NONE: err_d = 1'b1;
            default: begin
                sel_d = '0;
                err_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            Q   <= '0;
            ERR <= 1'b0;
        end else begin
            Q   <= sel_d;
            ERR <= err_d;
        end
    end

endmodule

// File: tb/tb_mux8_3to1.sv
// Directed bench for mux8_3to1: select, unmapped code, reset priority.
// Inputs change just after each rising edge; outputs checked there too.
module tb_mux8_3to1;

    import mux8_3to1_pkg::*;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    mux8_3to1_if #(.WIDTH(8)) bus ();

    mux8_3to1 #(.WIDTH(8)) dut (
        .CLK (clk),
        .RST (rst),
        .I1  (bus.i1),
        .I2  (bus.i2),
        .I3  (bus.i3),
        .S   (bus.s),
        .Q   (bus.q),
        .ERR (bus.err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst    = 1'b1;
        bus.i1 = 8'd1;
        bus.i2 = 8'd2;
        bus.i3 = 8'd3;
        bus.s  = 2'd0;
        tick();
        vectors++;
        if (bus.q !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_q got=%h exp=00", bus.q);
        end
        vectors++;
        if (bus.err !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_err got=%b exp=0", bus.err);
        end
    endtask

    task automatic test_select();
        logic [7:0] exp_q [3];
        exp_q[0] = 8'd1;
        exp_q[1] = 8'd2;
        exp_q[2] = 8'd3;
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            bus.s = 2'(k);
            tick();
            vectors++;
            if (bus.q !== exp_q[k]) begin
                miscompares++;
                $display("FAIL select_q s=%0d got=%h exp=%h",
                         k, bus.q, exp_q[k]);
            end
            vectors++;
            if (bus.err !== 1'b0) begin
                miscompares++;
                $display("FAIL select_err s=%0d got=%b exp=0",
                         k, bus.err);
            end
        end
        // Outputs must hold between edges even if inputs move.
        bus.i3 = 8'h77;
        #3;
        vectors++;
        if (bus.q !== 8'd3) begin
            miscompares++;
            $display("FAIL hold_q got=%h exp=03", bus.q);
        end
        bus.i3 = 8'd3;
    endtask

    task automatic test_unmapped();
        bus.s  = SEL_NONE;
        tick();
        vectors++;
        if (bus.q !== 8'h00 || bus.err !== 1'b1) begin
            miscompares++;
            $display("FAIL unmapped q=%h err=%b exp q=00 err=1",
                     bus.q, bus.err);
        end
        bus.i3 = 8'd33;
        tick();
        vectors++;
        if (bus.q !== 8'h00 || bus.err !== 1'b1) begin
            miscompares++;
            $display("FAIL unmapped_i3 q=%h err=%b exp q=00 err=1",
                     bus.q, bus.err);
        end
    endtask

    task automatic test_nonselected();
        bus.s  = SEL_I3;
        bus.i3 = 8'd3;
        tick();
        vectors++;
        if (bus.q !== 8'd3 || bus.err !== 1'b0) begin
            miscompares++;
            $display("FAIL nonsel_base q=%h err=%b exp q=03 err=0",
                     bus.q, bus.err);
        end
        bus.i1 = 8'hFF;
        tick();
        vectors++;
        if (bus.q !== 8'd3) begin
            miscompares++;
            $display("FAIL nonsel_i1 got=%h exp=03", bus.q);
        end
        bus.i3 = 8'hA5;
        tick();
        vectors++;
        if (bus.q !== 8'hA5) begin
            miscompares++;
            $display("FAIL nonsel_i3 got=%h exp=a5", bus.q);
        end
    endtask

    task automatic test_reset_mid();
        bus.s  = SEL_I2;
        bus.i2 = 8'd2;
        tick();
        vectors++;
        if (bus.q !== 8'd2) begin
            miscompares++;
            $display("FAIL mid_pre got=%h exp=02", bus.q);
        end
        rst = 1'b1;
        tick();
        vectors++;
        if (bus.q !== 8'h00 || bus.err !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_rst q=%h err=%b exp q=00 err=0",
                     bus.q, bus.err);
        end
        rst = 1'b0;
        tick();
        vectors++;
        if (bus.q !== 8'd2 || bus.err !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_post q=%h err=%b exp q=02 err=0",
                     bus.q, bus.err);
        end
    endtask

    task automatic test_back_to_back();
        bus.s  = SEL_NONE;
        tick();
        // Select and data change together: new code on new data.
        bus.s  = SEL_I3;
        bus.i3 = 8'hC3;
        tick();
        vectors++;
        if (bus.q !== 8'hC3 || bus.err !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_i3 q=%h err=%b exp q=c3 err=0",
                     bus.q, bus.err);
        end
        bus.s  = SEL_I1;
        bus.i1 = 8'h5A;
        tick();
        vectors++;
        if (bus.q !== 8'h5A) begin
            miscompares++;
            $display("FAIL b2b_i1 got=%h exp=5a", bus.q);
        end
        bus.s  = SEL_I2;
        bus.i2 = 8'h80;
        tick();
        vectors++;
        if (bus.q !== 8'h80) begin
            miscompares++;
            $display("FAIL b2b_i2 got=%h exp=80", bus.q);
        end
        bus.s  = SEL_I1;
        bus.i1 = 8'hFF;
        tick();
        vectors++;
        if (bus.q !== 8'hFF || bus.err !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_ones q=%h err=%b exp q=ff err=0",
                     bus.q, bus.err);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        bus.i1      = '0;
        bus.i2      = '0;
        bus.i3      = '0;
        bus.s       = '0;
        test_reset();
        test_select();
        test_unmapped();
        test_nonselected();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mux8_3to1.md
MUX8_3TO1 -- requirements
Module: mux8_3to1

Interface
- REQ-001 Parameter: WIDTH, default 8, data width of every data input and of Q.
- REQ-002 Port: CLK  input  1  single clock; all state updates on its rising edge.
- REQ-003 Port: RST  input  1  reset, synchronous and active-high.
- REQ-004 Port: I1  input  WIDTH  data input one, selected by code 0.
- REQ-005 Port: I2  input  WIDTH  data input two, selected by code 1.
- REQ-006 Port: I3  input  WIDTH  data input three, selected by code 2.
- REQ-007 Port: S  input  2  select code.
- REQ-008 Port: Q  output  WIDTH  registered selected data.
- REQ-009 Port: ERR  output  1  registered flag, high when the sampled select code was 3 (unmapped).
- REQ-010 No other ports; I1, I2, I3 and S have no handshake and are sampled every rising CLK edge.

Function
- REQ-011 The selection SHALL be S=0 -> I1, S=1 -> I2, S=2 -> I3, S=3 -> all-zero.
- REQ-012 Q SHALL update on every rising CLK edge with RST low to the selected value; latency is exactly one cycle from S/data sample to Q.
- REQ-013 ERR SHALL update on the same edge to 1 when the sampled S equals 3, else 0.
- REQ-014 With S=3, Q SHALL be all-zero regardless of I1, I2, I3 (changing I3 while S=3 does not affect Q).
- REQ-015 Changes on a non-selected input SHALL NOT change Q on the next edge.
- REQ-016 A select change and a data change in the same cycle SHALL both take effect on the same next edge (new S applied to new data).
- REQ-017 Q and ERR SHALL be held stable between rising edges; no combinational path from any input to Q or ERR.
- REQ-018 Data SHALL pass bit-exact; no width extension, truncation or arithmetic.

Reset
- REQ-019 When RST is high at a rising CLK edge, Q SHALL become all-zero and ERR SHALL become 0.
- REQ-020 RST SHALL take priority over selection; inputs are ignored on reset edges.
- REQ-021 Reset asserted mid-operation SHALL clear outputs on that edge; the first edge with RST low SHALL load the current selection normally.
- REQ-022 Outputs before the first reset edge are undefined; the bench SHALL apply reset first.

Structure
- REQ-023 Select-code constants SEL_I1=0, SEL_I2=1, SEL_I3=2, SEL_NONE=3 and the WIDTH default SHALL live in the shared package.
- REQ-024 Single module: combinational select case plus one output register stage; no sub-module.
- REQ-025 The select case SHALL be full (explicit default branch) so no latch is inferred.

Verification
- REQ-026 RST=1 for one edge with I1=1, I2=2, I3=3, S=0 -> Q=0, ERR=0.
- REQ-027 RST=0, I1=1, I2=2, I3=3; S=0, 1, 2 on successive edges -> Q=1, 2, 3 one edge later each, ERR=0.
- REQ-028 S=3, I1=1, I2=2, I3=3 -> Q=0, ERR=1; then I3=33 with S=3 -> Q stays 0, ERR=1.
- REQ-029 S=2, I3=3, change I1 to 8'hFF -> Q stays 3; change I3 to 8'hA5 -> Q=8'hA5 next edge.
- REQ-030 S=1, I2=2, Q=2 steady; assert RST one edge -> Q=0, ERR=0; deassert -> Q=2 on following edge.
